sweep_ctrl: RTL
===============

Name: sweep_ctrl

Overview:
Frequency-sweep controller that sequences the sinegen datapath. It drives the datapath's en, incr and offset inputs so the generated tone steps from a start increment to a stop increment, holding each step for a programmable dwell time. It supports single-shot and continuous-loop sweeps and sits between the top-level control inputs and sinegen.

Parameters:
D_WIDTH, 8, width of incr/offset values (matches sinegen D_WIDTH)
DWELL_WIDTH, 16, width of the dwell-cycle count

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
start  input  1  single-cycle request to begin a sweep; sampled only in IDLE
abort  input  1  terminate the sweep; takes effect at the next edge
loop  input  1  sampled at start; 1 = restart from incr_start after the final step, 0 = single shot
incr_start  input  D_WIDTH  first increment value
incr_stop  input  D_WIDTH  final increment value
incr_step  input  D_WIDTH  magnitude of the change per step
dwell  input  DWELL_WIDTH  en-high cycles per step; 0 is treated as 1
offset_in  input  D_WIDTH  phase offset for the second sine port
en  output  1  drives sinegen en
incr  output  D_WIDTH  drives sinegen incr
offset  output  D_WIDTH  drives sinegen offset
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse when a single-shot sweep completes normally

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset (synchronous): state=IDLE; en=0, incr=0, offset=0, busy=0, done=0. Reset has priority over every other input, including mid-sweep; no done pulse is produced.
- All outputs are registered.
- States are IDLE and RUN.
- IDLE:
  - en=0, busy=0; incr and offset hold their last values.
  - start=1 and abort=0 at edge t: latch incr_start, incr_stop, incr_step, dwell and loop.
  - Direction is latched as up if incr_stop >= incr_start, else down.
  - Set offset=offset_in, incr=incr_start, en=1, busy=1. The dwell counter is loaded with max(dwell,1)-1. Go to RUN.
  - The first en=1 cycle is therefore cycle t+1.
  - start and abort asserted together in IDLE: the start is ignored.
- RUN:
  - Each cycle with the dwell counter nonzero: decrement it.
  - Dwell counter == 0 (end of step): if incr == latched stop, or incr_step == 0, this is the final step:
    - loop=0: go to IDLE with en=0, busy=0, done=1 for exactly one cycle.
    - loop=1: incr=incr_start, reload the counter, stay in RUN; no done pulse.
  - Otherwise, compute the next value in D_WIDTH+1 bits:
    - Up: incr + incr_step, clamped to stop.
    - Down: incr - incr_step, clamped to stop (a negative result also clamps to stop).
    - No wrap-around is ever permitted.
    - Load the next value and reload the counter.
  - Each increment value is therefore held for exactly max(dwell,1) consecutive en=1 cycles.
  - abort=1 in RUN: next edge goes to IDLE with en=0, busy=0, done=0. Abort has priority over an end-of-step event in the same cycle.
  - start in RUN is ignored. Input config changes during RUN have no effect, because values are latched.
- offset is constant for the whole sweep; offset_in changes are ignored until the next start.
- done is never asserted in loop mode or on abort.
- Total en-high cycles for a single-shot sweep = number_of_steps × max(dwell,1).

Test Plan:
- Up sweep, single shot:
  - Stimulus: start=10, stop=40, step=10, dwell=3, loop=0, start pulse at cycle 0.
  - Expected: incr = 10,10,10,20,20,20,30,30,30,40,40,40 on cycles 1-12 with en=1. Cycle 13: en=0, busy=0, done=1. Cycle 14: done=0.
- Down sweep with clamp:
  - Stimulus: start=40, stop=5, step=20, dwell=1.
  - Expected: incr = 40,20,5, then done on cycle 4.
- Overflow clamp and dwell=0:
  - Stimulus: start=250, stop=255, step=10, dwell=0.
  - Expected: incr = 250,255 (never wraps to 4), then done on cycle 3.
- Zero step:
  - Stimulus: step=0, start=7, stop=20, dwell=2.
  - Expected: incr = 7,7, then done.
- Loop and abort:
  - Stimulus: start=1, stop=3, step=1, dwell=1, loop=1.
  - Expected: incr = 1,2,3,1,2,3,… with no done.
  - Abort at cycle 5: cycle 6 has en=0, busy=0, done=0.
- Reset and ignored inputs:
  - start re-pulsed mid-sweep: ignored, and the sequence is unchanged.
  - offset_in changed mid-sweep: offset keeps its value latched at start.
  - rst asserted mid-sweep: next cycle en=0, incr=0, offset=0, busy=0, done=0.
  - start and abort together in IDLE: stays IDLE.

Source files
------------

// File: rtl/sweep_ctrl_if.sv
// sweep_ctrl_if: control inputs and sinegen drive outputs of the sweep controller
interface sweep_ctrl_if #(
  parameter int D_WIDTH     = 8,
  parameter int DWELL_WIDTH = 16
);
  logic                   start;
  logic                   abort;
  logic                   loop;
  logic [D_WIDTH-1:0]     incr_start;
  logic [D_WIDTH-1:0]     incr_stop;
  logic [D_WIDTH-1:0]     incr_step;
  logic [DWELL_WIDTH-1:0] dwell;
  logic [D_WIDTH-1:0]     offset_in;
  logic                   en;
  logic [D_WIDTH-1:0]     incr;
  logic [D_WIDTH-1:0]     offset;
  logic                   busy;
  logic                   done;
  modport master (
    output start, abort, loop, incr_start, incr_stop, incr_step, dwell, offset_in,
    input  en, incr, offset, busy, done
  );
  modport slave (
    input  start, abort, loop, incr_start, incr_stop, incr_step, dwell, offset_in,
    output en, incr, offset, busy, done
  );
endinterface

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: steps sinegen incr from a start to a stop value, holding each step for a dwell time
module sweep_ctrl #(
  parameter int D_WIDTH     = 8,
  parameter int DWELL_WIDTH = 16
) (
  input logic         clk,
  input logic         rst,
  sweep_ctrl_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t                 state_q, state_n;
  logic                   en_q, en_n, busy_q, busy_n, done_q, done_n;
  logic                   loop_q, loop_n, up_q, up_n;
  logic [D_WIDTH-1:0]     incr_q, incr_n, offset_q, offset_n;
  logic [D_WIDTH-1:0]     start_q, start_n, stop_q, stop_n, step_q, step_n;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_n, cnt_q, cnt_n;
  logic [D_WIDTH:0]       sum, diff;
  logic [D_WIDTH-1:0]     nxt;
  logic                   last;
  function automatic logic [DWELL_WIDTH-1:0] reload(input logic [DWELL_WIDTH-1:0] d);
    return (d == '0) ? '0 : d - DWELL_WIDTH'(1);
  endfunction
  // Next value is formed one bit wider so overflow/underflow clamp to stop instead of wrapping
  assign sum  = {1'b0, incr_q} + {1'b0, step_q};
  assign diff = {1'b0, incr_q} - {1'b0, step_q};
  assign nxt  = up_q ? ((sum > {1'b0, stop_q}) ? stop_q : sum[D_WIDTH-1:0])
                     : ((diff[D_WIDTH] || diff[D_WIDTH-1:0] < stop_q) ? stop_q : diff[D_WIDTH-1:0]);
  assign last = (incr_q == stop_q) || (step_q == '0);
  always_comb begin
    state_n  = state_q;
    en_n     = en_q;
    busy_n   = busy_q;
    done_n   = 1'b0;
    loop_n   = loop_q;
    up_n     = up_q;
    incr_n   = incr_q;
    offset_n = offset_q;
    start_n  = start_q;
    stop_n   = stop_q;
    step_n   = step_q;
    dwell_n  = dwell_q;
    cnt_n    = cnt_q;
    if (state_q == IDLE) begin
      en_n   = 1'b0;
      busy_n = 1'b0;
      if (bus.start && !bus.abort) begin
        state_n  = RUN;
        en_n     = 1'b1;
        busy_n   = 1'b1;
        loop_n   = bus.loop;
        up_n     = bus.incr_stop >= bus.incr_start;
        start_n  = bus.incr_start;
        stop_n   = bus.incr_stop;
        step_n   = bus.incr_step;
        dwell_n  = bus.dwell;
        incr_n   = bus.incr_start;
        offset_n = bus.offset_in;
        cnt_n    = reload(bus.dwell);
      end
    end else if (bus.abort) begin
      state_n = IDLE;
      en_n    = 1'b0;
      busy_n  = 1'b0;
    end else if (cnt_q != '0) begin
      cnt_n = cnt_q - DWELL_WIDTH'(1);
    end else if (last && !loop_q) begin
      state_n = IDLE;
      en_n    = 1'b0;
      busy_n  = 1'b0;
      done_n  = 1'b1;
    end else begin
      incr_n = last ? start_q : nxt;
      cnt_n  = reload(dwell_q);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      loop_q   <= 1'b0;
      up_q     <= 1'b0;
      incr_q   <= '0;
      offset_q <= '0;
      start_q  <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_n;
      en_q     <= en_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      loop_q   <= loop_n;
      up_q     <= up_n;
      incr_q   <= incr_n;
      offset_q <= offset_n;
      start_q  <= start_n;
      stop_q   <= stop_n;
      step_q   <= step_n;
      dwell_q  <= dwell_n;
      cnt_q    <= cnt_n;
    end
  end
  assign bus.en     = en_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.incr   = incr_q;
  assign bus.offset = offset_q;
endmodule
